// File: rtl/tcdm_dummy_mem_pkg.sv
// Shared types, constants and helpers for the TCDM dummy memory model.
package tcdm_dummy_mem_pkg;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hcafe_f00d;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_port_t;

  function automatic logic [31:0] addr_offset(input logic [31:0] add,
                                              input logic [31:0] base,
                                              input logic [31:0] size);
    return (add - base) % size;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] state);
    return (state >> 1) ^ (state[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/tcdm_dummy_mem_stall_gen.sv
// Per-port free-running LFSR and pseudo-random stall decision.
module tcdm_dummy_mem_stall_gen
  import tcdm_dummy_mem_pkg::*;
#(
  parameter int unsigned PROB_STALL = 0,
  parameter logic [31:0] SEED       = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallable,
  output logic        stall,
  output logic [31:0] lfsr
);

  // An all-zero seed would lock the LFSR, so fall back to 1
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED_EFF;
    else     lfsr <= lfsr_step(lfsr);
  end

  assign stall = stallable && (PROB_STALL != 0) &&
                 ((lfsr % 32'd100) < 32'(PROB_STALL));

endmodule

// File: rtl/tcdm_dummy_memory.sv
// Multi-port single-cycle TCDM slave memory with random grant stalls.
// Per-port grant counters are built only when TCDM_DUMMY_MEM_COUNTERS_EN is defined.
module tcdm_dummy_memory
  import tcdm_dummy_mem_pkg::*;
#(
  parameter int unsigned MP          = 1,
  parameter int unsigned MEMORY_SIZE = 196608,
  parameter logic [31:0] BASE_ADDR   = 32'h1c00_0000,
  parameter int unsigned PROB_STALL  = 0,
  parameter logic [31:0] SEED        = DEFAULT_SEED
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 stallable_i,
  input  logic                 randomize_i,
  input  logic [MP-1:0]        req_i,
  output logic [MP-1:0]        gnt_o,
  input  logic [MP-1:0][31:0]  add_i,
  input  logic [MP-1:0]        wen_i,
  input  logic [MP-1:0][3:0]   be_i,
  input  logic [MP-1:0][31:0]  data_i,
  output logic [MP-1:0][31:0]  r_data_o,
  output logic [MP-1:0]        r_valid_o,
  output logic [MP-1:0][31:0]  cnt_rd_o,
  output logic [MP-1:0][31:0]  cnt_wr_o
);

  localparam int unsigned AW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

  // Byte array, not touched by reset; benches preload it hierarchically
  logic [7:0]    memory [0:MEMORY_SIZE-1];

  tcdm_port_t    port     [MP];
  logic [MP-1:0] stall;
  logic [MP-1:0] gnt;
  logic [31:0]   lfsr     [MP];
  logic [AW-1:0] byte_idx [MP][4];

  assign gnt_o = gnt;

  for (genvar gi = 0; gi < MP; gi++) begin : g_port
    logic        rvalid_reg;
    logic [31:0] rdata_reg;

    assign port[gi] = '{req: req_i[gi], add: add_i[gi], wen: wen_i[gi],
                        be: be_i[gi], data: data_i[gi]};

    tcdm_dummy_mem_stall_gen #(
      .PROB_STALL (PROB_STALL),
      .SEED       (SEED ^ 32'(gi))
    ) i_stall_gen (
      .clk       (clk_i),
      .rst       (rst_i),
      .stallable (stallable_i),
      .stall     (stall[gi]),
      .lfsr      (lfsr[gi])
    );

    assign gnt[gi] = port[gi].req & enable_i & ~stall[gi];

    // Each byte wraps independently so a word straddling the end stays in range
    for (genvar bi = 0; bi < 4; bi++) begin : g_byte
      assign byte_idx[gi][bi] = AW'(addr_offset(port[gi].add + 32'(bi),
                                                BASE_ADDR, MEMORY_SIZE));
    end

    // Non-granted and write responses carry 0 or LFSR noise, never stale data
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= gnt[gi];
        if (gnt[gi] && port[gi].wen)
          rdata_reg <= {memory[byte_idx[gi][3]], memory[byte_idx[gi][2]],
                        memory[byte_idx[gi][1]], memory[byte_idx[gi][0]]};
        else if (randomize_i)
          rdata_reg <= lfsr[gi];
        else
          rdata_reg <= '0;
      end
    end

    assign r_valid_o[gi] = rvalid_reg;
    assign r_data_o[gi]  = rdata_reg;

`ifdef TCDM_DUMMY_MEM_COUNTERS_EN
    logic [31:0] cnt_rd_reg;
    logic [31:0] cnt_wr_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_rd_reg <= '0;
        cnt_wr_reg <= '0;
      end else begin
        if (gnt[gi] && port[gi].wen && (cnt_rd_reg != 32'hffff_ffff))
          cnt_rd_reg <= cnt_rd_reg + 32'd1;
        if (gnt[gi] && !port[gi].wen && (cnt_wr_reg != 32'hffff_ffff))
          cnt_wr_reg <= cnt_wr_reg + 32'd1;
      end
    end

    assign cnt_rd_o[gi] = cnt_rd_reg;
    assign cnt_wr_o[gi] = cnt_wr_reg;
`else
    assign cnt_rd_o[gi] = '0;
    assign cnt_wr_o[gi] = '0;
`endif
  end

  // Ascending port loop with non-blocking updates: highest port wins a byte
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (gnt[p] && !port[p].wen && port[p].be[b])
          memory[byte_idx[p][b]] <= port[p].data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tcdm_dummy_memory.sv
// Directed self-checking bench for tcdm_dummy_memory (9 ports, 50% stall probability).
module tb_tcdm_dummy_memory;

  localparam int          MP    = 9;
  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int unsigned MSIZE = 196608;
  localparam logic [31:0] ADDR_A = 32'h1c01_0000;
  localparam logic [31:0] ADDR_B = 32'h1c01_0004;
  localparam logic [31:0] ADDR_C = 32'h1c01_0008;
  localparam logic [31:0] ADDR_D = 32'h1c01_0010;

`ifdef TCDM_DUMMY_MEM_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic enable, stallable, randomize;
  logic [MP-1:0]       req, gnt, wen, r_valid;
  logic [MP-1:0][31:0] add, data, r_data, cnt_rd, cnt_wr;
  logic [MP-1:0][3:0]  be;

  int n_checks = 0;
  int n_bad    = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;

  always #5 clk = ~clk;

  tcdm_dummy_memory #(
    .MP          (MP),
    .MEMORY_SIZE (MSIZE),
    .BASE_ADDR   (BASE),
    .PROB_STALL  (50),
    .SEED        (32'hcafe_f00d)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .stallable_i (stallable),
    .randomize_i (randomize),
    .req_i       (req),
    .gnt_o       (gnt),
    .add_i       (add),
    .wen_i       (wen),
    .be_i        (be),
    .data_i      (data),
    .r_data_o    (r_data),
    .r_valid_o   (r_valid),
    .cnt_rd_o    (cnt_rd),
    .cnt_wr_o    (cnt_wr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req = '0; wen = '1; be = '0; add = '0; data = '0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; wen[p] = w; add[p] = a; be[p] = b; data[p] = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_rd"}, cnt_rd[0], CNT_EN ? 32'(exp_rd) : 32'h0);
    check({tag, "_cnt_wr"}, cnt_wr[0], CNT_EN ? 32'(exp_wr) : 32'h0);
  endtask

  // One port-0 transaction: grant in the same cycle, response one cycle later
  task automatic access0(input string tag, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] exp_data);
    idle();
    set_port(0, w, a, b, d);
    #1;
    check({tag, "_gnt"}, 32'(gnt[0]), 32'h1);
    tick();
    idle();
    check({tag, "_rvalid"}, 32'(r_valid[0]), 32'h1);
    check({tag, "_rdata"}, r_data[0], exp_data);
    if (w) exp_rd++; else exp_wr++;
    $display("txn %s port=0 %s addr=%h be=%b wdata=%h rdata=%h",
             tag, w ? "rd" : "wr", a, b, d, r_data[0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v1;
    int grants, stalls, rvalids, cycles, data_err;

    rst = 1'b1; enable = 1'b1; stallable = 1'b0; randomize = 1'b0;
    idle();
    tick(); tick();
    check("rst_rvalid", 32'(r_valid), 32'h0);
    for (int p = 0; p < MP; p++) begin
      check($sformatf("rst_rdata%0d", p), r_data[p], 32'h0);
      check($sformatf("rst_cnt_rd%0d", p), cnt_rd[p], 32'h0);
      check($sformatf("rst_cnt_wr%0d", p), cnt_wr[p], 32'h0);
    end
    rst = 1'b0;

    // Basic write then read
    access0("wr_A", 1'b0, ADDR_A, 4'hf, 32'hdeadbeef, 32'h0);
    access0("rd_A", 1'b1, ADDR_A, 4'h0, 32'h0, 32'hdeadbeef);
    check_counters("after_A");

    // Partial byte-enable write
    access0("wr_B", 1'b0, ADDR_B, 4'hf, 32'haabbccdd, 32'h0);
    access0("wr_B_be", 1'b0, ADDR_B, 4'b0101, 32'h11223344, 32'h0);
    access0("rd_B", 1'b1, ADDR_B, 4'h0, 32'h0, 32'haa22cc44);
    tick();
    check("idle_rvalid", 32'(r_valid), 32'h0);

    // Read and write of the same word in one cycle: read sees old data
    access0("wr_C", 1'b0, ADDR_C, 4'hf, 32'hcafebabe, 32'h0);
    idle();
    set_port(0, 1'b0, ADDR_C, 4'hf, 32'h12345678);
    set_port(1, 1'b1, ADDR_C, 4'h0, 32'h0);
    #1;
    check("rw_C_gnt", 32'(gnt), 32'h003);
    tick();
    idle();
    exp_wr++;
    check("rw_C_rvalid", 32'(r_valid), 32'h003);
    check("rw_C_rdata1", r_data[1], 32'hcafebabe);
    $display("txn rw_C port=1 rd addr=%h rdata=%h", ADDR_C, r_data[1]);
    access0("rd_C", 1'b1, ADDR_C, 4'h0, 32'h0, 32'h12345678);

    // All ports write the same word; highest index wins
    idle();
    for (int p = 0; p < MP; p++) set_port(p, 1'b0, ADDR_D, 4'hf, 32'(p));
    #1;
    check("all_wr_gnt", 32'(gnt), 32'h1ff);
    tick();
    idle();
    exp_wr++;
    check("all_wr_rvalid", 32'(r_valid), 32'h1ff);
    $display("txn all_wr ports=0..8 wr addr=%h", ADDR_D);
    access0("rd_D", 1'b1, ADDR_D, 4'h0, 32'h0, 32'h8);

    // Address wrap: BASE+MSIZE aliases BASE
    access0("wr_wrap", 1'b0, BASE + MSIZE, 4'hf, 32'h0badf00d, 32'h0);
    access0("rd_wrap", 1'b1, BASE, 4'h0, 32'h0, 32'h0badf00d);
    check_counters("after_wrap");

    // enable=0 blocks grants; raising it grants in the same cycle
    enable = 1'b0;
    idle();
    set_port(0, 1'b1, ADDR_A, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("dis_gnt%0d", i), 32'(gnt[0]), 32'h0);
      tick();
      check($sformatf("dis_rvalid%0d", i), 32'(r_valid[0]), 32'h0);
    end
    enable = 1'b1;
    #1;
    check("en_gnt", 32'(gnt[0]), 32'h1);
    tick();
    idle();
    exp_rd++;
    check("en_rvalid", 32'(r_valid[0]), 32'h1);
    check("en_rdata", r_data[0], 32'hdeadbeef);

    // randomize_i: idle responses carry changing nonzero LFSR values
    randomize = 1'b1;
    tick();
    check("rand_rvalid", 32'(r_valid[0]), 32'h0);
    check("rand_nonzero", 32'(r_data[0] != 32'h0), 32'h1);
    v1 = r_data[0];
    tick();
    check("rand_changes", 32'(r_data[0] != v1), 32'h1);
    randomize = 1'b0;
    tick();
    check("unrand_rdata", r_data[0], 32'h0);

    // Random stalls on a held read request
    stallable = 1'b1;
    grants = 0; stalls = 0; rvalids = 0; cycles = 0; data_err = 0;
    idle();
    set_port(0, 1'b1, ADDR_A, 4'h0, 32'h0);
    while (grants < 1000 && cycles < 20000) begin
      #1;
      if (gnt[0]) grants++; else stalls++;
      cycles++;
      tick();
      if (r_valid[0]) begin
        rvalids++;
        if (r_data[0] !== 32'hdeadbeef) data_err++;
      end
    end
    idle();
    tick();
    check("stall_tail_rvalid", 32'(r_valid[0]), 32'h0);
    check("stall_grants", 32'(grants), 32'd1000);
    check("stall_rvalids", 32'(rvalids), 32'(grants));
    check("stall_data_err", 32'(data_err), 32'h0);
    check("stall_frac_ok", 32'((stalls * 100 >= cycles * 40) && (stalls * 100 <= cycles * 60)), 32'h1);
    $display("txn stall_run grants=%0d stalls=%0d cycles=%0d", grants, stalls, cycles);
    exp_rd += grants;
    stallable = 1'b0;
    check_counters("after_stall");

    // Async reset while a read is in flight
    idle();
    set_port(0, 1'b1, ADDR_A, 4'h0, 32'h0);
    tick();
    check("pre_rst_rvalid", 32'(r_valid[0]), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_rvalid", 32'(r_valid[0]), 32'h0);
    check("rst_gnt_follows", 32'(gnt[0]), 32'h1);
    tick();
    check("rst_hold_rvalid", 32'(r_valid[0]), 32'h0);
    exp_rd = 0; exp_wr = 0;
    check_counters("in_rst");
    rst = 1'b0;
    idle();
    access0("rd_A_post_rst", 1'b1, ADDR_A, 4'h0, 32'h0, 32'hdeadbeef);
    access0("rd_D_post_rst", 1'b1, ADDR_D, 4'h0, 32'h0, 32'h8);
    check_counters("post_rst");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
